// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a wide add through an external 4-bit
// combinational carry adder, one nibble slice per cycle, and assembles the
// wide sum together with the final carry-out and the signed-overflow flag.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_overflow
);

  localparam int W  = 4 * NIBBLES;
  // Slice index needs at least one bit even for a single-nibble build.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  acc_reg;
  logic [W-1:0]  acc_next;
  logic          carry_reg;
  logic [IW-1:0] idx_reg;
  logic          last_slice;

  // Nibble views of the captured operands so the slice mux is a plain index.
  logic [3:0] a_nib [NIBBLES];
  logic [3:0] b_nib [NIBBLES];

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[4*gi +: 4];
    assign b_nib[gi] = b_reg[4*gi +: 4];
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign last_slice = (idx_reg == LAST_IDX);

  // Adder drive: the current slice and running carry in RUN, zeros otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state_reg == RUN) begin
      add_a   = a_nib[idx_reg];
      add_b   = b_nib[idx_reg];
      add_cin = carry_reg;
    end
  end

  // Partial sum with this cycle's adder result merged into the active slice;
  // on the last slice this is the complete result.
  always_comb begin
    acc_next = acc_reg;
    if (state_reg == RUN) begin
      acc_next[4*idx_reg +: 4] = add_s;
    end
  end

  // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand capture, slice stepping and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      carry_reg    <= 1'b0;
      idx_reg      <= '0;
      out_sum      <= '0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            acc_reg   <= '0;
            carry_reg <= in_cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= add_cout;
          idx_reg   <= idx_reg + IW'(1);
          if (last_slice) begin
            // Outputs only change here, so they hold through DONE and IDLE.
            out_sum      <= acc_next;
            out_cout     <= add_cout;
            out_overflow <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]);
            idx_reg      <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
